dmem_access_ctrl: RTL

//  Multi-cycle data-memory access sequencer between the MEM stage and the word-wide data bus.

---
 rtl/dmem_access_ctrl_pkg.sv | 43 ++++
 rtl/dmem_access_ctrl_if.sv | 22 ++
 rtl/dmem_access_ctrl_lane_align.sv | 39 +++
 rtl/dmem_access_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access sequencer: access sizes, response
// error codes, FSM states and the byte-enable / alignment helpers.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] BE_SB = 2'b00;
    localparam logic [1:0] BE_SH = 2'b01;
    localparam logic [1:0] BE_SW = 2'b10;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BUS     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] becalc(input logic [1:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (op)
            BE_SW:   be = 4'b1111;
            BE_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            BE_SB:   be = 4'b0001 << a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Reserved size codes are reported the same way as a misaligned access.
    function automatic logic access_fault(input logic [1:0] op, input logic [1:0] a);
        logic f;
        case (op)
            BE_SW:   f = (a != 2'b00);
            BE_SH:   f = a[0];
            BE_SB:   f = 1'b0;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Word-wide data bus between the access sequencer (master) and memory (slave).
interface dmem_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    // bus_req is held until the cycle in which bus_ack or bus_err is seen;
    // bus_rdata is only meaningful in that same cycle.
    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_lane_align.sv
// Lane steering: store data replication across the word, and load lane
// extraction with sign/zero extension.
module dmem_access_ctrl_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  st_op,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_wrep,
    input  logic [1:0]  ld_op,
    input  logic        ld_uns,
    input  logic [1:0]  ld_alo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wrep = st_wdata;
        case (st_op)
            BE_SB:   st_wrep = {4{st_wdata[7:0]}};
            BE_SH:   st_wrep = {2{st_wdata[15:0]}};
            default: st_wrep = st_wdata;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_alo, 3'b000} +: 8];
        ld_half = ld_alo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = ld_word;
        case (ld_op)
            BE_SB:   ld_data = ld_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            BE_SH:   ld_data = ld_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store sequencer between the MEM stage and the data bus:
// IDLE -> REQ -> DONE -> IDLE, with IDLE -> DONE on an alignment fault.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_op,
    input  logic                req_uns,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                stall,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic [1:0]          resp_err,
    dmem_access_ctrl_if.master  dbus,
    output state_t              dbg_state
);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            ld_we;
    logic [1:0]      ld_op;
    logic            ld_uns;
    logic [1:0]      ld_alo;
    logic [31:0]     st_wrep;
    logic [31:0]     ld_data;

    dmem_access_ctrl_lane_align u_lane_align (
        .st_op    (req_op),
        .st_wdata (req_wdata),
        .st_wrep  (st_wrep),
        .ld_op    (ld_op),
        .ld_uns   (ld_uns),
        .ld_alo   (ld_alo),
        .ld_word  (dbus.bus_rdata),
        .ld_data  (ld_data)
    );

    // Gated by rst so a reset taken while a request is pending releases the pipeline at once.
    assign stall     = (state == ST_REQ) || (state == ST_IDLE && req_valid && !rst);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            to_cnt         <= '0;
            ld_we          <= 1'b0;
            ld_op          <= 2'b00;
            ld_uns         <= 1'b0;
            ld_alo         <= 2'b00;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_err       <= ERR_OK;
            dbus.bus_req   <= 1'b0;
            dbus.bus_we    <= 1'b0;
            dbus.bus_addr  <= 32'd0;
            dbus.bus_be    <= 4'd0;
            dbus.bus_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        ld_we  <= req_we;
                        ld_op  <= req_op;
                        ld_uns <= req_uns;
                        ld_alo <= req_addr[1:0];
                        to_cnt <= '0;
                        if (access_fault(req_op, req_addr[1:0])) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= ERR_ALIGN;
                            resp_rdata <= 32'd0;
                        end else begin
                            state          <= ST_REQ;
                            dbus.bus_req   <= 1'b1;
                            dbus.bus_we    <= req_we;
                            dbus.bus_addr  <= {req_addr[31:2], 2'b00};
                            dbus.bus_be    <= becalc(req_op, req_addr[1:0]);
                            dbus.bus_wdata <= st_wrep;
                        end
                    end
                end
                ST_REQ: begin
                    if (dbus.bus_err) begin
                        state        <= ST_DONE;
                        dbus.bus_req <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_err     <= ERR_BUS;
                        resp_rdata   <= 32'd0;
                    end else if (dbus.bus_ack) begin
                        state        <= ST_DONE;
                        dbus.bus_req <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_err     <= ERR_OK;
                        resp_rdata   <= ld_we ? 32'd0 : ld_data;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        // Bus has been requested for TIMEOUT cycles without an answer.
                        state        <= ST_DONE;
                        dbus.bus_req <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_err     <= ERR_TIMEOUT;
                        resp_rdata   <= 32'd0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
